// File: rtl/coin_conditioner.sv
// Coin sensor front end: synchronizes and debounces the nickel/dime sensors, queues
// one coin per channel and issues single-cycle pulses to the vending FSM.
module coin_conditioner #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEBOUNCE    = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic nickel_in,
  input  logic dime_in,
  input  logic dispense,
  output logic nickel,
  output logic dime,
  output logic reject
);

  localparam int unsigned CW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

  // Channel index 0 is the nickel sensor, 1 is the dime sensor.
  logic [1:0] sensor;
  logic [1:0] rise_c;
  logic [1:0] pend;
  logic [1:0] grant_c;
  logic       issue_c;

  assign sensor = {dime_in, nickel_in};

  for (genvar i = 0; i < 2; i++) begin : g_chan
    logic [SYNC_STAGES-1:0] sync;
    logic                   deb;
    logic [CW-1:0]          cnt;

    // Synchronizer and debouncer: deb follows the synchronized level only after
    // it has disagreed with deb for DEBOUNCE consecutive cycles.
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        sync <= '0;
        deb  <= 1'b0;
        cnt  <= '0;
      end else begin
        sync <= {sync[SYNC_STAGES-2:0], sensor[i]};
        if (sync[SYNC_STAGES-1] == deb) begin
          cnt <= '0;
        end else if (cnt == CNT_LAST) begin
          deb <= ~deb;
          cnt <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end

    // Coin event: deb is about to rise on this edge.
    assign rise_c[i] = !deb && sync[SYNC_STAGES-1] && (cnt == CNT_LAST);
  end

  // Issue arbiter: dime first, never while dispensing or right after a pulse.
  always_comb begin
    issue_c = (|pend) && !dispense && !nickel && !dime;
    grant_c = 2'b00;
    if (issue_c) begin
      grant_c = pend[1] ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pend   <= 2'b00;
      nickel <= 1'b0;
      dime   <= 1'b0;
      reject <= 1'b0;
    end else begin
      nickel <= grant_c[0];
      dime   <= grant_c[1];
      // A new event on a channel whose coin is being issued simply re-arms it.
      reject <= |(rise_c & pend & ~grant_c);
      pend   <= rise_c | (pend & ~grant_c);
    end
  end

endmodule

// File: tb/tb_coin_conditioner.sv
// Directed bench for coin_conditioner: an event-level reference model checked every
// cycle, plus hand-computed pulse counts and pulse edges per scenario.
module tb_coin_conditioner;

  localparam int S = 2;
  localparam int D = 16;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic nickel_in = 1'b0;
  logic dime_in = 1'b0;
  logic dispense = 1'b0;
  logic nickel, dime, reject;

  int errors = 0;
  int checks = 0;

  coin_conditioner #(.SYNC_STAGES(S), .DEBOUNCE(D)) dut (
    .clock(clock),
    .reset(reset),
    .nickel_in(nickel_in),
    .dime_in(dime_in),
    .dispense(dispense),
    .nickel(nickel),
    .dime(dime),
    .reject(reject)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: raw samples per edge; a level reaches deb once the last D
  // synchronized samples all disagree with it.
  bit hist [2][64];
  int m_edges;
  bit m_deb [2];
  bit m_pend [2];
  bit m_n, m_d, m_rej;
  bit t_rise [2];
  bit t_grant [2];
  bit t_go, t_differ;

  function automatic bit seen(input int ch, input int e);
    if (e < S) return 1'b0;
    return hist[ch][(e - S) % 64];
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_edges = 0;
      for (int c = 0; c < 2; c++) begin
        m_deb[c] = 1'b0;
        m_pend[c] = 1'b0;
        for (int k = 0; k < 64; k++) hist[c][k] = 1'b0;
      end
      m_n = 1'b0;
      m_d = 1'b0;
      m_rej = 1'b0;
    end else begin
      hist[0][m_edges % 64] = nickel_in;
      hist[1][m_edges % 64] = dime_in;
      for (int c = 0; c < 2; c++) begin
        t_differ = 1'b1;
        for (int j = 0; j < D; j++)
          if (seen(c, m_edges - j) == m_deb[c]) t_differ = 1'b0;
        t_rise[c] = t_differ && !m_deb[c];
        if (t_differ) m_deb[c] = !m_deb[c];
      end
      t_go = (m_pend[0] || m_pend[1]) && !dispense && !m_n && !m_d;
      t_grant[1] = t_go && m_pend[1];
      t_grant[0] = t_go && !m_pend[1];
      m_rej = (t_rise[0] && m_pend[0] && !t_grant[0]) ||
              (t_rise[1] && m_pend[1] && !t_grant[1]);
      for (int c = 0; c < 2; c++)
        m_pend[c] = t_rise[c] || (m_pend[c] && !t_grant[c]);
      m_n = t_grant[0];
      m_d = t_grant[1];
      m_edges++;
    end
  end

  always @(negedge clock) begin
    check("model_nickel", nickel, m_n);
    check("model_dime", dime, m_d);
    check("model_reject", reject, m_rej);
  end

  // Per-scenario pulse counters, edges numbered from the stimulus change.
  int edge_no = 0;
  int n_cnt, d_cnt, r_cnt, n_first, d_first, r_first;

  always @(posedge clock) edge_no++;

  always @(negedge clock) begin
    if (nickel === 1'b1) begin n_cnt++; if (n_first == 0) n_first = edge_no; end
    if (dime === 1'b1)   begin d_cnt++; if (d_first == 0) d_first = edge_no; end
    if (reject === 1'b1) begin r_cnt++; if (r_first == 0) r_first = edge_no; end
  end

  task automatic begin_case();
    edge_no = 0;
    n_cnt = 0; d_cnt = 0; r_cnt = 0;
    n_first = 0; d_first = 0; r_first = 0;
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(negedge clock);
    #1;
  endtask

  initial begin
    #1 reset = 1'b0;
    wait_edges(3);
    check("reset_nickel", nickel, 1'b0);
    check("reset_dime", dime, 1'b0);
    check("reset_reject", reject, 1'b0);
    reset = 1'b1;
    wait_edges(2);

    // Single nickel
    begin_case(); nickel_in = 1'b1; wait_edges(30);
    expect_int("single_nickel_count", n_cnt, 1);
    expect_int("single_nickel_edge", n_first, 19);
    expect_int("single_dime_count", d_cnt, 0);
    expect_int("single_reject_count", r_cnt, 0);
    nickel_in = 1'b0; wait_edges(25);

    // Bouncy dime
    begin_case();
    dime_in = 1'b1; wait_edges(10);
    dime_in = 1'b0; wait_edges(3);
    dime_in = 1'b1; wait_edges(40);
    expect_int("bounce_dime_count", d_cnt, 1);
    expect_int("bounce_dime_edge", d_first, 32);
    expect_int("bounce_nickel_count", n_cnt, 0);
    dime_in = 1'b0; wait_edges(25);

    // 15-cycle glitch
    begin_case(); dime_in = 1'b1; wait_edges(15); dime_in = 1'b0; wait_edges(40);
    expect_int("glitch_dime_count", d_cnt, 0);

    // Simultaneous coins
    begin_case(); nickel_in = 1'b1; dime_in = 1'b1; wait_edges(30);
    expect_int("simul_dime_edge", d_first, 19);
    expect_int("simul_nickel_edge", n_first, 21);
    expect_int("simul_dime_count", d_cnt, 1);
    expect_int("simul_nickel_count", n_cnt, 1);
    expect_int("simul_reject_count", r_cnt, 0);
    nickel_in = 1'b0; dime_in = 1'b0; wait_edges(25);

    // Dispense hold-off
    begin_case(); nickel_in = 1'b1; wait_edges(18);
    dispense = 1'b1; wait_edges(3);
    dispense = 1'b0; wait_edges(10);
    expect_int("holdoff_nickel_edge", n_first, 22);
    expect_int("holdoff_nickel_count", n_cnt, 1);
    nickel_in = 1'b0; wait_edges(25);

    // Overflow while dispensing
    begin_case(); dispense = 1'b1;
    nickel_in = 1'b1; wait_edges(25);
    nickel_in = 1'b0; wait_edges(25);
    nickel_in = 1'b1; wait_edges(25);
    expect_int("overflow_reject_count", r_cnt, 1);
    expect_int("overflow_reject_edge", r_first, 68);
    expect_int("overflow_nickel_held", n_cnt, 0);
    dispense = 1'b0; wait_edges(10);
    expect_int("overflow_nickel_count", n_cnt, 1);
    nickel_in = 1'b0; wait_edges(25);

    // Asynchronous reset mid-operation
    begin_case(); dispense = 1'b1; dime_in = 1'b1; wait_edges(20);
    dime_in = 1'b0; nickel_in = 1'b1; wait_edges(8);
    dispense = 1'b0; wait_edges(1);
    check("midreset_dime_before", dime, 1'b1);
    #1 reset = 1'b0;
    #1;
    check("midreset_nickel", nickel, 1'b0);
    check("midreset_dime", dime, 1'b0);
    check("midreset_reject", reject, 1'b0);
    nickel_in = 1'b0; dime_in = 1'b0;
    wait_edges(3);
    reset = 1'b1;
    begin_case(); wait_edges(40);
    expect_int("postreset_nickel_count", n_cnt, 0);
    expect_int("postreset_dime_count", d_cnt, 0);
    expect_int("postreset_reject_count", r_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
